// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Data always wins; one transaction is in flight at a time, ended by bus ack or timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                flush_i,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
  output logic                err_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic                stallreq_from_if_o,
  output logic                stallreq_from_mem_o,
  output logic [1:0]          dbg_state_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    D_BUSY   = 2'd1,
    IF_BUSY  = 2'd2,
    IF_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                err_q, err_d;
  logic                timed_out;
  logic [CNT_W-1:0]    cnt_inc;

  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_VAL);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // The requester still holds req during its ack pulse; granting then would re-issue it.
        if (!(if_ack_q || d_ack_q)) begin
          if (d_req_i) begin
            state_d     = D_BUSY;
            cnt_d       = '0;
            bus_we_d    = d_we_i;
            bus_addr_d  = d_addr_i;
            bus_wdata_d = d_wdata_i;
            bus_sel_d   = d_sel_i;
          end else if (if_req_i && !flush_i) begin
            state_d    = IF_BUSY;
            cnt_d      = '0;
            bus_we_d   = 1'b0;
            bus_addr_d = if_addr_i;
            bus_sel_d  = '1;
          end
        end
      end
      D_BUSY: begin
        if (bus_ack_i) begin
          d_rdata_d = bus_rdata_i;
          d_ack_d   = 1'b1;
          state_d   = IDLE;
        end else if (timed_out) begin
          d_rdata_d = '0;
          d_ack_d   = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IF_BUSY: begin
        if (bus_ack_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            if_rdata_d = bus_rdata_i;
            if_ack_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          if (!flush_i) begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
            err_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (flush_i) state_d = IF_DRAIN;
        end
      end
      IF_DRAIN: begin
        // Killed fetch: let the bus finish, report nothing.
        if (bus_ack_i || timed_out) state_d = IDLE;
        else                        cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_req_o           = (state_q != IDLE);
  assign bus_we_o            = bus_we_q;
  assign bus_addr_o          = bus_addr_q;
  assign bus_wdata_o         = bus_wdata_q;
  assign bus_sel_o           = bus_sel_q;
  assign if_rdata_o          = if_rdata_q;
  assign d_rdata_o           = d_rdata_q;
  assign if_ack_o            = if_ack_q;
  assign d_ack_o             = d_ack_q;
  assign err_o               = err_q;
  assign stallreq_from_if_o  = if_req_i & ~if_ack_q;
  assign stallreq_from_mem_o = d_req_i & ~d_ack_q;
  assign dbg_state_o         = state_q;

endmodule
